idu_issue_ctrl: RTL and testbench
=================================

Name: idu_issue_ctrl

Overview:
- Issue controller between the IDU and the EXU on the decoded-instruction pipe.
- Holds one decoded instruction in a stage register and keeps a register scoreboard plus an in-flight counter.
- Releases the held instruction to the EXU only when it is free of RAW/WAW hazards, capacity limits and system-instruction serialization.
- Carries control fields only; the wide payload register is clocked elsewhere using this block's accept/fire strobes.

Parameters:
- NR_REGS, 16, architectural register count (RV32E); register index width is clog2(NR_REGS) = 4.
- MAX_INFLIGHT, 4, maximum number of issued, not-yet-written-back instructions.
- CNT_W, 32, stall performance counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  IDU offers a decoded instruction.
- in_ready  out  1  controller can accept.
- in_rs1  in  4  source register 1 (0 = none/x0).
- in_rs2  in  4  source register 2.
- in_rd  in  4  destination register.
- in_wen  in  1  instruction writes rd.
- in_system  in  1  csr_wen/ecall/ebreak/mret class; must issue serialized.
- accept  out  1  in_valid && in_ready (payload register load enable).
- out_valid  out  1  held instruction issuable to EXU.
- out_ready  in  1  EXU accepts.
- fire  out  1  out_valid && out_ready.
- wb_valid  in  1  an issued instruction completes.
- wb_rd  in  4  its destination (0 if none).
- flush  in  1  redirect; drop the held instruction.
- busy_vec  out  NR_REGS  scoreboard (bit i = write pending to reg i).
- inflight  out  clog2(MAX_INFLIGHT)+1  outstanding count.
- stall_cnt  out  CNT_W  cycles with hold_valid && !out_valid.

Behaviour:
- Reset values: hold_valid=0, busy_vec=0, inflight=0, stall_cnt=0. Consequently out_valid=0, fire=0, and in_ready=1 after reset.
- Effective write: hwen = hold_wen && hold_rd!=0. busy_vec bit 0 is always 0.
- hazard = (hold_rs1!=0 && busy[hold_rs1]) | (hold_rs2!=0 && busy[hold_rs2]) | (hwen && busy[hold_rd]) | (inflight==MAX_INFLIGHT) | (hold_system && inflight!=0).
- out_valid = hold_valid && !hazard && !flush. This output is combinational from registers plus flush.
- in_ready = !hold_valid || fire || flush.
  - Accept with no hold or with fire gives back-to-back throughput of 1 instruction/cycle.
  - An instruction accepted in the flush cycle is kept; flush kills only the old hold.
- Stage register: on accept, load rs1/rs2/rd/wen/system and set hold_valid=1. Otherwise, fire or flush clears hold_valid.
- On fire: if hwen, busy[hold_rd] is set; inflight increments.
- On wb_valid: busy[wb_rd] is cleared (no-op for 0); inflight decrements.
- When fire and wb_valid occur in the same cycle:
  - inflight is unchanged.
  - For the same register, set wins.
- wb_valid with inflight==0 is a protocol error: inflight saturates at 0, and a simulation assertion fires.
- Scoreboard bits set by already-issued instructions are never cleared by flush; the EXU still writes back or retires them with wb_valid.
- System serialization:
  - A held system instruction waits until inflight==0.
  - While a system instruction is in flight (inflight!=0 and it was last issued), younger instructions are not blocked by this rule, only by normal hazards. The EXU is in-order, so this is sufficient.
- stall_cnt increments every cycle that hold_valid && !out_valid && !flush holds, and wraps modulo 2^CNT_W.
- Async reset mid-operation discards the hold and clears the scoreboard; the surrounding pipeline is reset together.

Optional Feature:
- Macro IDU_ISSUE_WB_BYPASS_EN.
- Defined: hazard evaluation uses busy_vec with the bit for a same-cycle wb_rd masked off, and inflight as seen after that cycle's wb decrement. A dependent instruction therefore issues in the writeback cycle, provided the EXU forwards the result.
- Undefined: hazard uses registered busy_vec/inflight only, giving one bubble cycle after writeback.

Decomposition:
- Shared package ysyx_pkg gets the register index typedef (4-bit), NR_REGS and MAX_INFLIGHT defaults.
- One sub-module, idu_scoreboard: busy_vec register with set/clear ports and a read-check of rs1/rs2/rd returning a hazard bit.
- The top holds the stage register, inflight counter, serialization logic and stall counter.

Test Plan:
- Reset, then offer `add x5,x1,x2` with out_ready=1 → out_valid the cycle after accept; busy_vec=0x0020; inflight=1.
- Next instruction reads x5 with no wb → out_valid stays 0 and stall_cnt counts 3 cycles; wb_valid with wb_rd=5 → issues the next cycle, or in the same cycle with IDU_ISSUE_WB_BYPASS_EN.
- Issue 4 independent writers with no wb → 5th held (inflight=4); one wb → 5th issues, inflight stays 4.
- A system instruction held with inflight=2 → waits for 2 wb, then issues when inflight==0.
- Hazard-stalled hold plus flush with in_valid=1 in the same cycle → old hold dropped, no fire, new instruction accepted; busy_vec unchanged.
- fire and wb_valid on the same rd in one cycle → busy bit remains 1 and inflight is unchanged; rd=0 writer → busy_vec bit 0 stays 0.

Source files
------------

// File: rtl/ysyx_pkg.sv
// rtl/ysyx_pkg.sv - shared register-index type and issue-control defaults
package ysyx_pkg;

    localparam int NR_REGS      = 16;
    localparam int MAX_INFLIGHT = 4;
    localparam int REG_IDX_W    = 4;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

endpackage

// File: rtl/idu_scoreboard.sv
// rtl/idu_scoreboard.sv - register write-pending scoreboard with RAW/WAW hazard check (IDU_ISSUE_WB_BYPASS_EN)
module idu_scoreboard
    import ysyx_pkg::*;
#(
    parameter int NR_REGS = ysyx_pkg::NR_REGS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               set_en,
    input  reg_idx_t           set_rd,
    input  logic               clr_en,
    input  reg_idx_t           clr_rd,
    input  reg_idx_t           rs1,
    input  reg_idx_t           rs2,
    input  reg_idx_t           rd,
    input  logic               rd_wen,
    output logic [NR_REGS-1:0] busy_vec,
    output logic               hazard
);

    logic [NR_REGS-1:0] busy_q;
    logic [NR_REGS-1:0] busy_d;
    logic [NR_REGS-1:0] busy_view;

    // Clear for the completing writer first, then set for the issuing one so set wins on the same register
    always_comb begin
        busy_d = busy_q;
        if (clr_en) begin
            busy_d[clr_rd] = 1'b0;
        end
        if (set_en) begin
            busy_d[set_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Scoreboard register; x0 never becomes pending
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

`ifdef IDU_ISSUE_WB_BYPASS_EN
    // A register being written back this cycle is forwarded by the EXU, so it no longer blocks
    always_comb begin
        busy_view = busy_q;
        if (clr_en) begin
            busy_view[clr_rd] = 1'b0;
        end
    end
`else
    // Only registered state is consulted, costing one bubble after writeback
    always_comb begin
        busy_view = busy_q;
    end
`endif

    // RAW on either source, WAW on the destination; x0 is never a dependency
    always_comb begin
        hazard = ((rs1 != '0) && busy_view[rs1])
               | ((rs2 != '0) && busy_view[rs2])
               | (rd_wen && (rd != '0) && busy_view[rd]);
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/idu_issue_ctrl.sv
// rtl/idu_issue_ctrl.sv - IDU-to-EXU issue stage with hazard, capacity and serialization gating (IDU_ISSUE_WB_BYPASS_EN)
module idu_issue_ctrl
    import ysyx_pkg::*;
#(
    parameter int NR_REGS      = ysyx_pkg::NR_REGS,
    parameter int MAX_INFLIGHT = ysyx_pkg::MAX_INFLIGHT,
    parameter int CNT_W        = 32,
    localparam int IF_W        = $clog2(MAX_INFLIGHT) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  reg_idx_t           in_rs1,
    input  reg_idx_t           in_rs2,
    input  reg_idx_t           in_rd,
    input  logic               in_wen,
    input  logic               in_system,
    output logic               accept,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               fire,
    input  logic               wb_valid,
    input  reg_idx_t           wb_rd,
    input  logic               flush,
    output logic [NR_REGS-1:0] busy_vec,
    output logic [IF_W-1:0]    inflight,
    output logic [CNT_W-1:0]   stall_cnt
);

    logic      hold_valid;
    reg_idx_t  hold_rs1;
    reg_idx_t  hold_rs2;
    reg_idx_t  hold_rd;
    logic      hold_wen;
    logic      hold_system;
    logic      hwen;
    logic      sb_hazard;
    logic      hazard;
    logic      wb_dec;
    logic [IF_W-1:0] inflight_view;

    assign hwen   = hold_wen && (hold_rd != '0);
    assign wb_dec = wb_valid && (inflight != '0);

    idu_scoreboard #(.NR_REGS(NR_REGS)) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_en   (fire && hwen),
        .set_rd   (hold_rd),
        .clr_en   (wb_valid),
        .clr_rd   (wb_rd),
        .rs1      (hold_rs1),
        .rs2      (hold_rs2),
        .rd       (hold_rd),
        .rd_wen   (hold_wen),
        .busy_vec (busy_vec),
        .hazard   (sb_hazard)
    );

`ifdef IDU_ISSUE_WB_BYPASS_EN
    // Capacity and serialization see the count after this cycle's writeback
    always_comb begin
        inflight_view = inflight - IF_W'(wb_dec);
    end
`else
    // Capacity and serialization see the registered count only
    always_comb begin
        inflight_view = inflight;
    end
`endif

    // Issue gating: scoreboard, capacity, system serialization, then handshake strobes
    always_comb begin
        hazard    = sb_hazard
                  | (inflight_view == IF_W'(MAX_INFLIGHT))
                  | (hold_system && (inflight_view != '0));
        out_valid = hold_valid && !hazard && !flush;
        fire      = out_valid && out_ready;
        in_ready  = !hold_valid || fire || flush;
        accept    = in_valid && in_ready;
    end

    // Stage register: a new accept overrides the fire/flush clear of the old hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_valid  <= 1'b0;
            hold_rs1    <= '0;
            hold_rs2    <= '0;
            hold_rd     <= '0;
            hold_wen    <= 1'b0;
            hold_system <= 1'b0;
        end else if (accept) begin
            hold_valid  <= 1'b1;
            hold_rs1    <= in_rs1;
            hold_rs2    <= in_rs2;
            hold_rd     <= in_rd;
            hold_wen    <= in_wen;
            hold_system <= in_system;
        end else if (fire || flush) begin
            hold_valid  <= 1'b0;
        end
    end

    // Outstanding count: +1 per issue, -1 per writeback, saturating at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= '0;
        end else if (fire && !wb_valid) begin
            inflight <= inflight + 1'b1;
        end else if (!fire && wb_dec) begin
            inflight <= inflight - 1'b1;
        end
    end

    // Stall performance counter, free-running modulo 2^CNT_W
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (hold_valid && !out_valid && !flush) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    wb_without_inflight: assert property (@(posedge clk) disable iff (rst) !(wb_valid && (inflight == '0)));

endmodule

// File: tb/tb_idu_issue_ctrl.sv
// tb/tb_idu_issue_ctrl.sv - self-checking bench for idu_issue_ctrl against a queue-based issue model
module tb_idu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_rs1;
    logic [3:0]  in_rs2;
    logic [3:0]  in_rd;
    logic        in_wen;
    logic        in_system;
    logic        accept;
    logic        out_valid;
    logic        out_ready;
    logic        fire;
    logic        wb_valid;
    logic [3:0]  wb_rd;
    logic        flush;
    logic [15:0] busy_vec;
    logic [2:0]  inflight;
    logic [31:0] stall_cnt;

    int errors = 0;
    int checks = 0;

    // Model: in-order EXU queue of issued destinations (0 = no write), plus the held instruction
    logic [3:0]  q[$];
    bit          m_hv;
    logic [3:0]  m_rs1, m_rs2, m_rd;
    bit          m_wen, m_sys;
    logic [31:0] m_stall;

    idu_issue_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_rd     (in_rd),
        .in_wen    (in_wen),
        .in_system (in_system),
        .accept    (accept),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .fire      (fire),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .flush     (flush),
        .busy_vec  (busy_vec),
        .inflight  (inflight),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_busy();
        logic [15:0] b = '0;
        foreach (q[i]) if (q[i] != 4'd0) b[q[i]] = 1'b1;
        return b;
    endfunction

    // One cycle: drive inputs, check outputs mid-cycle, advance model at the edge
    task automatic step(input bit iv, input logic [3:0] r1, input logic [3:0] r2, input logic [3:0] rdd,
                        input bit wn, input bit sy, input bit ordy, input bit wb, input bit fl);
        bit wbv, haz, e_ov, e_fire, e_ir, e_acc;
        logic [3:0]  wrd;
        logic [15:0] bview;
        int          iview;
        wbv = wb && (q.size() > 0);
        wrd = wbv ? q[0] : 4'd0;
        in_valid = iv; in_rs1 = r1; in_rs2 = r2; in_rd = rdd; in_wen = wn; in_system = sy;
        out_ready = ordy; wb_valid = wbv; wb_rd = wrd; flush = fl;
        #1;
        bview = model_busy();
        iview = q.size();
`ifdef IDU_ISSUE_WB_BYPASS_EN
        if (wbv) begin
            bview[wrd] = 1'b0;
            iview = iview - 1;
        end
`endif
        haz = (m_rs1 != 0 && bview[m_rs1]) || (m_rs2 != 0 && bview[m_rs2]) ||
              (m_wen && m_rd != 0 && bview[m_rd]) || (iview == 4) || (m_sys && iview != 0);
        e_ov   = m_hv && !haz && !fl;
        e_fire = e_ov && ordy;
        e_ir   = !m_hv || e_fire || fl;
        e_acc  = iv && e_ir;
        chk("out_valid", 32'(out_valid), 32'(e_ov));
        chk("fire", 32'(fire), 32'(e_fire));
        chk("in_ready", 32'(in_ready), 32'(e_ir));
        chk("accept", 32'(accept), 32'(e_acc));
        chk("busy_vec", 32'(busy_vec), 32'(model_busy()));
        chk("inflight", 32'(inflight), 32'(q.size()));
        chk("stall_cnt", stall_cnt, m_stall);
        @(posedge clk);
        if (m_hv && !e_ov && !fl) m_stall = m_stall + 1;
        if (wbv) void'(q.pop_front());
        if (e_fire) q.push_back((m_wen && m_rd != 0) ? m_rd : 4'd0);
        if (e_acc) begin
            m_hv = 1; m_rs1 = r1; m_rs2 = r2; m_rd = rdd; m_wen = wn; m_sys = sy;
        end else if (e_fire || fl) begin
            m_hv = 0;
        end
        @(negedge clk);
    endtask

    task automatic idle(input bit wb);
        step(0, 0, 0, 0, 0, 0, 1, wb, 0);
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() > 0 || m_hv) && n < 60) begin
            idle(1);
            n++;
        end
        chk("drain_bound", 32'(n < 60), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0; in_wen = 0; in_system = 0;
        out_ready = 0; wb_valid = 0; wb_rd = 0; flush = 0;
        m_hv = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_wen = 0; m_sys = 0; m_stall = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy_vec), 32'd0);
        chk("rst_inflight", 32'(inflight), 32'd0);
        chk("rst_stall", stall_cnt, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // add x5,x1,x2
        step(1, 1, 2, 5, 1, 0, 1, 0, 0);
        chk("add_out_valid", 32'(out_valid), 32'd1);
        idle(0);
        chk("add_busy", 32'(busy_vec), 32'h20);
        chk("add_inflight", 32'(inflight), 32'd1);

        // RAW on x5: three stalled cycles, then writeback releases it
        step(1, 5, 0, 6, 1, 0, 1, 0, 0);
        repeat (3) idle(0);
        chk("raw_stall3", stall_cnt, 32'd3);
        idle(1);
        idle(0);
        drain();

        // Capacity: four writers, the fifth waits
        for (int i = 1; i <= 5; i++) step(1, 0, 0, 4'(i + 2), 1, 0, 1, 0, 0);
        repeat (2) idle(0);
        chk("cap_inflight", 32'(inflight), 32'd4);
        chk("cap_held", 32'(out_valid), 32'd0);
        idle(1);
        idle(0);
        chk("cap_inflight_after", 32'(inflight), 32'd4);
        drain();

        // System instruction waits for two outstanding writebacks
        step(1, 0, 0, 1, 1, 0, 1, 0, 0);
        step(1, 0, 0, 2, 1, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 1, 1, 0, 0);
        idle(0);
        chk("sys_wait", 32'(out_valid), 32'd0);
        idle(1);
        idle(1);
        idle(0);
        drain();

        // Flush of a stalled hold while a new instruction is accepted
        step(1, 0, 0, 9, 1, 0, 1, 0, 0);
        step(1, 9, 0, 10, 1, 0, 1, 0, 0);
        idle(0);
        step(1, 0, 0, 11, 1, 0, 1, 0, 1);
        chk("flush_busy", 32'(busy_vec), 32'h200);
        idle(0);
        drain();

        // Writer to x0 never marks busy; writer pair on the same rd overlapping writeback
        step(1, 0, 0, 0, 1, 0, 1, 0, 0);
        idle(0);
        chk("x0_busy", 32'(busy_vec[0]), 32'd0);
        step(1, 0, 0, 3, 1, 0, 1, 1, 0);
        step(1, 0, 0, 3, 1, 0, 1, 0, 0);
        idle(1);
        idle(0);
        drain();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
